// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction
// memory port and buffers {pc, instr, fault} beats in an in-order queue for decode.
module imem_fetch_ctrl #(
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_instr,
  input  logic                          halt,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  output logic                          out_fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                PW      = $clog2(FIFO_DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(FIFO_DEPTH);
  localparam logic [31:0]       PC_LIM  = 32'(IMEM_DEPTH * 4);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  localparam entry_t HEAD_RST = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};

  entry_t          r_q [FIFO_DEPTH];
  entry_t          r_head;
  logic [31:0]     r_pc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_fault;
  entry_t          w_entry;
  logic            w_pop;
  logic            w_pop_eff;
  logic            w_push;
  logic [31:0]     w_target;
  logic [PW-1:0]   w_rd_nxt;
  logic [PW-1:0]   w_wr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     w_pc_nxt;
  entry_t          w_head_nxt;

  always_comb begin
    w_fault   = (r_pc >= PC_LIM);
    w_entry   = '{pc: r_pc, instr: (w_fault ? NOP_INSTR : imem_instr), fault: w_fault};
    w_pop     = (r_count != '0) & out_ready;
    w_pop_eff = w_pop & ~redirect_valid;
    w_push    = ~redirect_valid & ~halt & ((r_count < CNT_MAX) | w_pop);
    w_target  = redirect_pc & ~32'h3;
  end

  // A redirect flushes everything and discards any same-cycle pop.
  always_comb begin
    w_rd_nxt  = r_rd_ptr;
    w_wr_nxt  = r_wr_ptr;
    w_cnt_nxt = r_count;
    w_pc_nxt  = r_pc;
    if (redirect_valid) begin
      w_rd_nxt  = '0;
      w_wr_nxt  = '0;
      w_cnt_nxt = '0;
      w_pc_nxt  = w_target;
    end else begin
      w_rd_nxt  = r_rd_ptr + PW'(w_pop_eff);
      w_wr_nxt  = r_wr_ptr + PW'(w_push);
      w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop_eff);
      if (w_push) w_pc_nxt = r_pc + 32'd4;
    end
  end

  // The slot being written becomes the head only when the queue is otherwise empty.
  always_comb begin
    w_head_nxt = r_q[w_rd_nxt];
    if (w_push && (r_wr_ptr == w_rd_nxt)) w_head_nxt = w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= HEAD_RST;
    end else begin
      r_pc     <= w_pc_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_count  <= w_cnt_nxt;
      if (w_cnt_nxt != '0) r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= w_entry;
  end

  assign imem_addr  = r_pc;
  assign out_valid  = (r_count != '0);
  assign out_instr  = r_head.instr;
  assign out_pc     = r_head.pc;
  assign out_fault  = r_head.fault;
  assign fifo_count = r_count;

endmodule
